// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : frame-format encodings, FSM states and bit-timing helpers
// Rev 1.0
// ============================================================================
package uart_pkg;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic [3:0] data_width(input logic [1:0] code);
        case (code)
            DBITS_5: return 4'd5;
            DBITS_6: return 4'd6;
            DBITS_7: return 4'd7;
            DBITS_8: return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] code);
        return 8'((9'd1 << data_width(code)) - 9'd1);
    endfunction

    // Code 2'b11 is treated as "no parity", same as 2'b00.
    function automatic parity_t parity_decode(input logic [1:0] code);
        case (code)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_transmitter_cfg_if.sv
`default_nettype none
// ============================================================================
// uart_transmitter_cfg_if : byte push handshake into the transmit FIFO
// Rev 1.0
// ============================================================================
interface uart_transmitter_cfg_if;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (output data_in, output data_in_valid, input  data_in_ready);
    modport slave  (input  data_in, input  data_in_valid, output data_in_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : synchronous DEPTH x WIDTH FIFO with occupancy count
// Rev 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Push is gated by the registered full flag, so a same-cycle pop never frees a slot early.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_transmitter_cfg.sv
`default_nettype none
// ============================================================================
// uart_transmitter_cfg : FIFO-buffered UART TX with per-frame 5-8 / N,E,O / 1-2 format
// Rev 1.0
// ============================================================================
module uart_transmitter_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    uart_transmitter_cfg_if.slave        tx_if,
    input  logic [1:0]                   cfg_data_bits,
    input  logic [1:0]                   cfg_parity,
    input  logic                         cfg_stop2,
    output logic                         serial_out,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         frame_done
);
    localparam int              SET       = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int              TW        = (SET > 1) ? $clog2(SET) : 1;
    localparam logic [TW-1:0]   LAST_TICK = TW'(SET - 1);

    state_t        r_state,    w_state_n;
    logic [TW-1:0] r_timer,    w_timer_n;
    logic [2:0]    r_bit_idx,  w_bit_idx_n;
    logic [2:0]    r_last_idx, w_last_idx_n;
    logic          r_stop_idx, w_stop_idx_n;
    logic [7:0]    r_shift,    w_shift_n;
    parity_t       r_parity,   w_parity_n;
    logic          r_stop2,    w_stop2_n;
    logic          r_par_bit,  w_par_bit_n;
    logic          r_serial,   w_serial_n;
    logic          w_launch;
    logic          w_tick_end;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [7:0]    w_head;
    logic [7:0]    w_head_masked;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tx_if.data_in_valid),
        .push_data (tx_if.data_in),
        .pop       (w_launch),
        .pop_data  (w_head),
        .count     (fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign tx_if.data_in_ready = !w_fifo_full;
    assign w_head_masked       = w_head & data_mask(cfg_data_bits);

    always_comb begin
        w_state_n    = r_state;
        w_timer_n    = r_timer;
        w_bit_idx_n  = r_bit_idx;
        w_last_idx_n = r_last_idx;
        w_stop_idx_n = r_stop_idx;
        w_shift_n    = r_shift;
        w_parity_n   = r_parity;
        w_stop2_n    = r_stop2;
        w_par_bit_n  = r_par_bit;
        w_launch     = 1'b0;
        w_serial_n   = 1'b1;
        w_tick_end   = (r_timer == LAST_TICK);

        if (r_state != ST_IDLE) w_timer_n = w_tick_end ? '0 : r_timer + TW'(1);

        case (r_state)
            ST_IDLE: begin
                w_timer_n = '0;
                w_launch  = !w_fifo_empty;
            end
            ST_START: begin
                if (w_tick_end) begin
                    w_state_n   = ST_DATA;
                    w_bit_idx_n = '0;
                end
            end
            ST_DATA: begin
                if (w_tick_end) begin
                    if (r_bit_idx == r_last_idx) begin
                        w_state_n    = (r_parity == PAR_NONE) ? ST_STOP : ST_PARITY;
                        w_stop_idx_n = 1'b0;
                    end else begin
                        w_bit_idx_n = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick_end) begin
                    w_state_n    = ST_STOP;
                    w_stop_idx_n = 1'b0;
                end
            end
            ST_STOP: begin
                if (w_tick_end) begin
                    if (r_stop_idx == r_stop2) begin
                        w_state_n = ST_IDLE;
                        w_launch  = !w_fifo_empty;
                    end else begin
                        w_stop_idx_n = 1'b1;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        // Frame format is captured here only, so cfg_* changes wait for the next frame.
        if (w_launch) begin
            w_state_n    = ST_START;
            w_bit_idx_n  = '0;
            w_stop_idx_n = 1'b0;
            w_shift_n    = w_head_masked;
            w_last_idx_n = 3'(data_width(cfg_data_bits) - 4'd1);
            w_parity_n   = parity_decode(cfg_parity);
            w_stop2_n    = cfg_stop2;
            w_par_bit_n  = (^w_head_masked) ^ (parity_decode(cfg_parity) == PAR_ODD);
        end

        case (w_state_n)
            ST_START:  w_serial_n = 1'b0;
            ST_DATA:   w_serial_n = w_shift_n[w_bit_idx_n];
            ST_PARITY: w_serial_n = w_par_bit_n;
            default:   w_serial_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_last_idx <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_parity   <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_par_bit  <= 1'b0;
            r_serial   <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_timer    <= w_timer_n;
            r_bit_idx  <= w_bit_idx_n;
            r_last_idx <= w_last_idx_n;
            r_stop_idx <= w_stop_idx_n;
            r_shift    <= w_shift_n;
            r_parity   <= w_parity_n;
            r_stop2    <= w_stop2_n;
            r_par_bit  <= w_par_bit_n;
            r_serial   <= w_serial_n;
        end
    end

    assign serial_out = r_serial;
    assign frame_done = (r_state == ST_STOP) && w_tick_end && (r_stop_idx == r_stop2);
    assign busy       = (r_state != ST_IDLE) || (fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter_cfg.sv
`default_nettype none
// ============================================================================
// tb_uart_transmitter_cfg : randomized frame checks against a bit-list reference model
// Rev 1.0
// ============================================================================
module tb_uart_transmitter_cfg;

    localparam int CLK_HZ    = 125_000_000;
    localparam int FAST_BAUD = 11_520_000;
    localparam int SET_F     = CLK_HZ / FAST_BAUD;
    localparam int SET_S     = CLK_HZ / 115_200;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] cfg_data_bits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       serial_out, busy, frame_done;
    logic [2:0] fifo_count;
    logic       s_serial, s_busy, s_frame_done;
    logic [2:0] s_fifo_count;
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;

    uart_transmitter_cfg_if f_if ();
    uart_transmitter_cfg_if s_if ();

    uart_transmitter_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(FAST_BAUD), .FIFO_DEPTH(4)) u_fast (
        .clk(clk), .reset_n(reset_n), .tx_if(f_if),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .serial_out(serial_out), .busy(busy), .fifo_count(fifo_count), .frame_done(frame_done)
    );

    uart_transmitter_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(115_200), .FIFO_DEPTH(4)) u_slow (
        .clk(clk), .reset_n(reset_n), .tx_if(s_if),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .serial_out(s_serial), .busy(s_busy), .fifo_count(s_fifo_count), .frame_done(s_frame_done)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: number of symbols and the line level of each symbol, start bit first.
    function automatic int frame_syms(input int db, input int par, input int st2);
        return 1 + (5 + db) + ((par == 1 || par == 2) ? 1 : 0) + (st2 != 0 ? 2 : 1);
    endfunction

    function automatic logic [11:0] frame_bits(input int b, input int db, input int par, input int st2);
        logic [11:0] f;
        int n, ones, pos;
        f = '0; n = 5 + db; ones = 0; pos = 1;
        for (int i = 0; i < n; i++) begin
            f[pos] = ((b >> i) & 1) != 0;
            ones  += (b >> i) & 1;
            pos++;
        end
        if (par == 1) begin f[pos] = (ones % 2) == 1; pos++; end
        else if (par == 2) begin f[pos] = (ones % 2) == 0; pos++; end
        f[pos] = 1'b1;
        if (st2 != 0) f[pos + 1] = 1'b1;
        return f;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        f_if.data_in       = b;
        f_if.data_in_valid = 1'b1;
        while (f_if.data_in_ready !== 1'b1 && n < 200 * SET_F) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (f_if.data_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_accept: data_in_ready=%b after %0d cycles, required 1", f_if.data_in_ready, n);
        end
        @(negedge clk);
        f_if.data_in_valid = 1'b0;
    endtask

    // Observes one frame on the fast DUT; c=0 is the first negedge with the line low.
    task automatic capture_frame(input int nsym, output logic [11:0] obs, output logic [11:0] stab,
                                 output int done_at, output int n_done, output int gap,
                                 output int start_cyc, output bit timed_out);
        int w = 0;
        obs = '0; stab = '0; done_at = -1; n_done = 0; timed_out = 1'b0;
        while (serial_out !== 1'b0 && w < 40 * SET_F) begin
            @(negedge clk);
            w++;
        end
        gap = w;
        start_cyc = cyc;
        if (serial_out !== 1'b0) begin
            timed_out = 1'b1;
            return;
        end
        for (int c = 0; c < nsym * SET_F; c++) begin
            if (c % SET_F == 0) begin
                obs[c / SET_F]  = serial_out;
                stab[c / SET_F] = 1'b1;
            end else if (serial_out !== obs[c / SET_F]) begin
                stab[c / SET_F] = 1'b0;
            end
            if (frame_done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (serial_out !== 1'b1) begin failures++; $display("FAIL reset_serial: got %b need 1", serial_out); end
        checks++; if (f_if.data_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b need 1", f_if.data_in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b need 0", busy); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d need 0", fifo_count); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b need 0", frame_done); end
        checks++; if (s_serial !== 1'b1) begin failures++; $display("FAIL reset_slow_serial: got %b need 1", s_serial); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_8n1_default();
        logic [11:0] exp, obs;
        int done_at = -1, nd = 0, tr = 0, exp_tr = 0;
        logic prev;
        cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        exp = frame_bits(32'h55, 3, 0, 0);
        for (int i = 1; i < 10; i++) if (exp[i] != exp[i - 1]) exp_tr++;
        s_if.data_in = 8'h55; s_if.data_in_valid = 1'b1;
        @(negedge clk);
        s_if.data_in_valid = 1'b0;
        checks++;
        if (s_serial !== 1'b1 || s_fifo_count !== 3'd1) begin
            failures++; $display("FAIL slow_queued: serial=%b count=%0d need 1/1", s_serial, s_fifo_count);
        end
        @(negedge clk);
        checks++; if (s_serial !== 1'b0) begin failures++; $display("FAIL slow_start_latency: serial=%b need 0", s_serial); end
        obs = '0; prev = s_serial;
        for (int c = 0; c < 10 * SET_S; c++) begin
            if (c % SET_S == SET_S / 2) obs[c / SET_S] = s_serial;
            if (s_serial !== prev) tr++;
            prev = s_serial;
            if (s_frame_done === 1'b1) begin nd++; if (done_at < 0) done_at = c; end
            @(negedge clk);
        end
        checks++; if (obs !== exp) begin failures++; $display("FAIL slow_bits: got %b need %b", obs, exp); end
        checks++; if (tr != exp_tr) begin failures++; $display("FAIL slow_transitions: got %0d need %0d", tr, exp_tr); end
        checks++;
        if (done_at != 10 * SET_S - 1 || nd != 1) begin
            failures++; $display("FAIL slow_frame_done: at %0d count %0d need %0d/1", done_at, nd, 10 * SET_S - 1);
        end
        checks++;
        if (s_busy !== 1'b0 || s_serial !== 1'b1) begin
            failures++; $display("FAIL slow_idle_after: busy=%b serial=%b need 0/1", s_busy, s_serial);
        end
    endtask

    task automatic test_formats();
        logic [7:0]  b;
        logic [11:0] exp, obs, stab, m;
        int db, par, st2, nsym, done_at, nd, gap, st;
        bit to;
        for (int k = 0; k < 14; k++) begin
            if (k == 0)      begin b = 8'hC1; db = 2; par = 1; st2 = 0; end
            else if (k == 1) begin b = 8'h1F; db = 0; par = 2; st2 = 1; end
            else begin
                b = 8'($urandom); db = int'($urandom_range(0, 3));
                par = int'($urandom_range(0, 3)); st2 = int'($urandom_range(0, 1));
            end
            cfg_data_bits = 2'(db); cfg_parity = 2'(par); cfg_stop2 = 1'(st2);
            nsym = frame_syms(db, par, st2);
            exp  = frame_bits(int'(b), db, par, st2);
            m    = 12'((1 << nsym) - 1);
            push_byte(b);
            capture_frame(nsym, obs, stab, done_at, nd, gap, st, to);
            checks++;
            if (to || obs !== exp) begin
                failures++; $display("FAIL fmt_bits[%0d]: byte %h cfg %0d/%0d/%0d got %b need %b", k, b, db, par, st2, obs, exp);
            end
            checks++; if (stab !== m) begin failures++; $display("FAIL fmt_stable[%0d]: got %b need %b", k, stab, m); end
            checks++;
            if (done_at != nsym * SET_F - 1 || nd != 1) begin
                failures++; $display("FAIL fmt_frame_done[%0d]: at %0d count %0d need %0d/1", k, done_at, nd, nsym * SET_F - 1);
            end
            checks++; if (gap != 1) begin failures++; $display("FAIL fmt_latency[%0d]: got %0d need 1", k, gap); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fmt_busy_after[%0d]: got %b need 0", k, busy); end
        end
    endtask

    task automatic test_back_to_back();
        int acc[7];
        logic [11:0] obs[6], stab[6];
        int done_at[6], nd[6], gap[6], st[6];
        bit to[6];
        logic [11:0] exp;
        cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        fork
            begin
                f_if.data_in_valid = 1'b1;
                for (int i = 1; i <= 6; i++) begin
                    int n = 0;
                    f_if.data_in = 8'(i);
                    if (i == 6) begin
                        checks++;
                        if (f_if.data_in_ready !== 1'b0 || fifo_count !== 3'd4) begin
                            failures++; $display("FAIL b2b_full: ready=%b count=%0d need 0/4", f_if.data_in_ready, fifo_count);
                        end
                    end
                    while (f_if.data_in_ready !== 1'b1 && n < 40 * SET_F) begin @(negedge clk); n++; end
                    acc[i] = cyc + 1;
                    @(negedge clk);
                end
                f_if.data_in_valid = 1'b0;
            end
            begin
                for (int f = 0; f < 6; f++)
                    capture_frame(10, obs[f], stab[f], done_at[f], nd[f], gap[f], st[f], to[f]);
            end
        join
        for (int f = 0; f < 6; f++) begin
            exp = frame_bits(f + 1, 3, 0, 0);
            checks++;
            if (to[f] || obs[f] !== exp || stab[f] !== 12'h3FF || done_at[f] != 10 * SET_F - 1) begin
                failures++; $display("FAIL b2b_frame[%0d]: bits %b stable %b done %0d need %b/3ff/%0d", f, obs[f], stab[f], done_at[f], exp, 10 * SET_F - 1);
            end
            if (f > 0) begin
                checks++; if (gap[f] != 0) begin failures++; $display("FAIL b2b_gap[%0d]: got %0d need 0", f, gap[f]); end
            end
        end
        checks++; if (st[0] != acc[1] + 1) begin failures++; $display("FAIL b2b_first_start: edge %0d need %0d", st[0], acc[1] + 1); end
        checks++;
        if (acc[5] >= st[1] || acc[6] != st[1] + 1) begin
            failures++; $display("FAIL b2b_sixth_accept: 5th %0d 6th %0d frame2 %0d need 6th=%0d", acc[5], acc[6], st[1], st[1] + 1);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_after: got %b need 0", busy); end
    endtask

    task automatic test_cfg_change();
        logic [11:0] obs[2], stab[2], exp[2];
        int done_at[2], nd[2], gap[2], st[2], ns[2];
        bit to[2];
        cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        exp[0] = frame_bits(32'hA5, 3, 0, 0); ns[0] = frame_syms(3, 0, 0);
        exp[1] = frame_bits(32'h3C, 0, 1, 1); ns[1] = frame_syms(0, 1, 1);
        push_byte(8'hA5);
        push_byte(8'h3C);
        fork
            begin
                for (int f = 0; f < 2; f++)
                    capture_frame(ns[f], obs[f], stab[f], done_at[f], nd[f], gap[f], st[f], to[f]);
            end
            begin
                repeat (3 * SET_F) @(negedge clk);
                cfg_data_bits = 2'd0; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
            end
        join
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (to[f] || obs[f] !== exp[f] || done_at[f] != ns[f] * SET_F - 1 || gap[f] != 0) begin
                failures++; $display("FAIL cfg_change[%0d]: bits %b done %0d gap %0d need %b/%0d/0", f, obs[f], done_at[f], gap[f], exp[f], ns[f] * SET_F - 1);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] obs, stab, exp;
        int done_at, nd, gap, st, db, par, st2, nsym;
        logic [7:0] b;
        bit to, bad;
        cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        push_byte(8'h00); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        repeat (12) @(negedge clk);
        checks++;
        if (serial_out !== 1'b0 || fifo_count !== 3'd3) begin
            failures++; $display("FAIL rst_pre: serial=%b count=%0d need 0/3", serial_out, fifo_count);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (serial_out !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || f_if.data_in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_async: serial=%b count=%0d busy=%b ready=%b need 1/0/0/1", serial_out, fifo_count, busy, f_if.data_in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (8 * SET_F) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL rst_quiet: line or busy active after reset, need idle"); end
        b = 8'($urandom); db = int'($urandom_range(0, 3));
        par = int'($urandom_range(0, 2)); st2 = int'($urandom_range(0, 1));
        cfg_data_bits = 2'(db); cfg_parity = 2'(par); cfg_stop2 = 1'(st2);
        nsym = frame_syms(db, par, st2);
        exp  = frame_bits(int'(b), db, par, st2);
        push_byte(b);
        capture_frame(nsym, obs, stab, done_at, nd, gap, st, to);
        checks++;
        if (to || obs !== exp || done_at != nsym * SET_F - 1) begin
            failures++; $display("FAIL rst_recover: bits %b done %0d need %b/%0d", obs, done_at, exp, nsym * SET_F - 1);
        end
    endtask

    initial begin
        reset_n            = 1'b0;
        f_if.data_in       = 8'h00;
        f_if.data_in_valid = 1'b0;
        s_if.data_in       = 8'h00;
        s_if.data_in_valid = 1'b0;
        cfg_data_bits      = 2'd3;
        cfg_parity         = 2'd0;
        cfg_stop2          = 1'b0;
        test_reset();
        test_8n1_default();
        test_formats();
        test_back_to_back();
        test_cfg_change();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
